// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network datapath blocks.
package snn_pkg;
  localparam int CURRENT_W   = 8;
  localparam int CURRENT_MAX = 127;
  localparam int CURRENT_MIN = -128;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} syn_state_t;
endpackage

// File: rtl/sat_clip.sv
// Combinational signed saturation of a wide value into the CURRENT_W range.
module sat_clip
  import snn_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0]      din_i,
  output logic signed [CURRENT_W-1:0] dout_o
);
  localparam logic signed [IN_W-1:0] HI = IN_W'(CURRENT_MAX);
  localparam logic signed [IN_W-1:0] LO = IN_W'(CURRENT_MIN);

  always_comb begin
    if (din_i > HI)
      dout_o = CURRENT_W'(CURRENT_MAX);
    else if (din_i < LO)
      dout_o = CURRENT_W'(CURRENT_MIN);
    else
      dout_o = din_i[CURRENT_W-1:0];
  end
endmodule

// File: rtl/synapse_accumulator.sv
// Sums the weights of spiking inputs over one timestep, reading weights from an
// external 1-cycle memory, and emits a saturated current with a one-cycle valid.
//   state | meaning
//   IDLE  | waiting for start; current holds last result
//   FETCH | issuing one weight read per cycle, accumulating the previous one
//   DRAIN | folding in the final weight and publishing current
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int WEIGHT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N_INPUTS-1:0]           spikes_in,
  output logic [$clog2(N_INPUTS)-1:0]   w_addr,
  output logic                          w_rd_en,
  input  logic signed [WEIGHT_W-1:0]    w_data,
  output logic signed [CURRENT_W-1:0]   current,
  output logic                          current_valid,
  output logic                          busy
);
  localparam int ADDR_W = $clog2(N_INPUTS);
  localparam int ACC_W  = WEIGHT_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

  syn_state_t                  state_q;
  logic [N_INPUTS-1:0]         spk_q;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [ADDR_W-1:0]           idx_q, slot_q;
  logic                        rd_pending_q;
  logic signed [CURRENT_W-1:0] current_q, sat_out;
  logic                        current_valid_q;

  // The weight arriving this cycle belongs to the slot issued on the previous edge.
  always_comb begin
    acc_d = acc_q;
    if (rd_pending_q && spk_q[slot_q])
      acc_d = acc_q + ACC_W'(w_data);
  end

  sat_clip #(.IN_W(ACC_W)) u_sat (
    .din_i (acc_d),
    .dout_o(sat_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      spk_q           <= '0;
      acc_q           <= '0;
      idx_q           <= '0;
      slot_q          <= '0;
      rd_pending_q    <= 1'b0;
      current_q       <= '0;
      current_valid_q <= 1'b0;
    end else begin
      current_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            spk_q        <= spikes_in;
            acc_q        <= '0;
            idx_q        <= '0;
            rd_pending_q <= 1'b0;
            state_q      <= FETCH;
          end
        end
        FETCH: begin
          acc_q        <= acc_d;
          slot_q       <= idx_q;
          rd_pending_q <= 1'b1;
          if (idx_q == LAST_IDX)
            state_q <= DRAIN;
          else
            idx_q <= idx_q + ADDR_W'(1);
        end
        DRAIN: begin
          acc_q           <= acc_d;
          rd_pending_q    <= 1'b0;
          current_q       <= sat_out;
          current_valid_q <= 1'b1;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_rd_en       = (state_q == FETCH);
  assign w_addr        = idx_q;
  assign busy          = (state_q != IDLE);
  assign current       = current_q;
  assign current_valid = current_valid_q;
endmodule

// File: tb/tb_synapse_accumulator.sv
// Bench for synapse_accumulator with N_INPUTS=4 against a weighted-sum reference model.
module tb_synapse_accumulator;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [N-1:0]      spikes_in;
  logic [1:0]        w_addr;
  logic              w_rd_en;
  logic signed [7:0] w_data;
  logic signed [7:0] current;
  logic              current_valid;
  logic              busy;

  logic signed [7:0] rom [N];
  int total = 0;
  int bad   = 0;

  synapse_accumulator #(.N_INPUTS(N), .WEIGHT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .spikes_in    (spikes_in),
    .w_addr       (w_addr),
    .w_rd_en      (w_rd_en),
    .w_data       (w_data),
    .current      (current),
    .current_valid(current_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (w_rd_en) w_data <= rom[w_addr];

  function automatic int model(input logic [N-1:0] spk);
    int s = 0;
    for (int i = 0; i < N; i++) if (spk[i]) s += int'(rom[i]);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // Leaves the caller on the falling edge just after the start edge.
  task automatic kick(input logic [N-1:0] v);
    @(negedge clk);
    start = 1'b1;
    spikes_in = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; spikes_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (current !== 8'sd0) begin bad++; $display("FAIL reset_current got=%0d want=0", current); end
    total++; if (current_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", current_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (w_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", w_rd_en); end
    total++; if (w_addr !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", w_addr); end
  endtask

  task automatic test_directed();
    int exp;
    rom = '{8'sd10, -8'sd20, 8'sd30, 8'sd127};
    exp = model(4'b0101);
    kick(4'b0101);
    for (int k = 0; k <= 6; k++) begin
      logic exp_rd, exp_valid, exp_busy;
      exp_rd = (k < 4); exp_valid = (k == 5); exp_busy = (k < 5);
      total++; if (w_rd_en !== exp_rd) begin bad++; $display("FAIL dir_rd_en k=%0d got=%b want=%b", k, w_rd_en, exp_rd); end
      if (k < 4) begin
        total++; if (w_addr !== 2'(k)) begin bad++; $display("FAIL dir_addr k=%0d got=%0d want=%0d", k, w_addr, k); end
      end
      total++; if (current_valid !== exp_valid) begin bad++; $display("FAIL dir_valid k=%0d got=%b want=%b", k, current_valid, exp_valid); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL dir_busy k=%0d got=%b want=%b", k, busy, exp_busy); end
      if (k == 5) begin
        total++; if (int'(current) !== exp) begin bad++; $display("FAIL dir_current got=%0d want=%0d", current, exp); end
        total++; if (int'(current) !== 40) begin bad++; $display("FAIL dir_current_40 got=%0d want=40", current); end
      end
      @(negedge clk);
    end
    total++; if (int'(current) !== exp) begin bad++; $display("FAIL dir_hold got=%0d want=%0d", current, exp); end
  endtask

  task automatic test_saturation();
    rom = '{8'sd10, -8'sd20, 8'sd30, 8'sd127};
    kick(4'b1111);
    repeat (5) @(negedge clk);
    total++; if (current_valid !== 1'b1) begin bad++; $display("FAIL sat_hi_valid got=%b want=1", current_valid); end
    total++; if (int'(current) !== 127) begin bad++; $display("FAIL sat_hi got=%0d want=127", current); end
    rom = '{-8'sd100, -8'sd100, 8'sd0, 8'sd0};
    kick(4'b0011);
    repeat (5) @(negedge clk);
    total++; if (current_valid !== 1'b1) begin bad++; $display("FAIL sat_lo_valid got=%b want=1", current_valid); end
    total++; if (int'(current) !== -128) begin bad++; $display("FAIL sat_lo got=%0d want=-128", current); end
  endtask

  task automatic test_back_to_back();
    rom = '{8'sd10, -8'sd20, 8'sd30, 8'sd127};
    kick(4'b1111);
    repeat (5) @(negedge clk);
    kick(4'b0000);
    repeat (5) @(negedge clk);
    total++; if (current_valid !== 1'b1) begin bad++; $display("FAIL b2b_zero_valid got=%b want=1", current_valid); end
    total++; if (int'(current) !== 0) begin bad++; $display("FAIL b2b_zero got=%0d want=0", current); end
    start = 1'b1; spikes_in = 4'b0101;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
    repeat (5) @(negedge clk);
    total++; if (current_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", current_valid); end
    total++; if (int'(current) !== model(4'b0101)) begin bad++; $display("FAIL b2b_second got=%0d want=%0d", current, model(4'b0101)); end
  endtask

  task automatic test_ignore_start();
    int nvalid = 0;
    int exp;
    rom = '{8'sd10, -8'sd20, 8'sd30, 8'sd127};
    exp = model(4'b0101);
    kick(4'b0101);
    for (int k = 0; k < 16; k++) begin
      start = (k == 1 || k == 4);
      spikes_in = (k == 0) ? 4'b1010 : 4'($urandom_range(0, 15));
      if (current_valid === 1'b1) nvalid++;
      if (k == 5) begin
        total++; if (int'(current) !== exp) begin bad++; $display("FAIL ign_current got=%0d want=%0d", current, exp); end
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (nvalid !== 1) begin bad++; $display("FAIL ign_valid_count got=%0d want=1", nvalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    rom = '{8'sd10, -8'sd20, 8'sd30, 8'sd127};
    kick(4'b1111);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (current !== 8'sd0) begin bad++; $display("FAIL rmid_current got=%0d want=0", current); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (w_rd_en !== 1'b0) begin bad++; $display("FAIL rmid_rd_en got=%b want=0", w_rd_en); end
    total++; if (w_addr !== 2'd0) begin bad++; $display("FAIL rmid_addr got=%0d want=0", w_addr); end
    total++; if (current_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", current_valid); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (current_valid === 1'b1) nvalid++;
      @(negedge clk);
    end
    total++; if (nvalid !== 0) begin bad++; $display("FAIL rmid_no_valid got=%0d want=0", nvalid); end
    kick(4'b0101);
    repeat (5) @(negedge clk);
    total++; if (current_valid !== 1'b1) begin bad++; $display("FAIL rmid_after_valid got=%b want=1", current_valid); end
    total++; if (int'(current) !== 40) begin bad++; $display("FAIL rmid_after got=%0d want=40", current); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      logic [N-1:0] v;
      int exp, lat;
      for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 255));
      v = 4'($urandom_range(0, 15));
      exp = model(v);
      kick(v);
      lat = -1;
      for (int k = 0; k < 10 && lat < 0; k++) begin
        if (current_valid === 1'b1) lat = k;
        else begin
          spikes_in = 4'($urandom_range(0, 15));
          @(negedge clk);
        end
      end
      total++; if (lat !== 5) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d want=5", it, lat); end
      total++; if (int'(current) !== exp) begin bad++; $display("FAIL rnd_current it=%0d spk=%b got=%0d want=%0d", it, v, current, exp); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
